// File: rtl/beat_clock.sv
// beat_clock: tempo-controlled beat counter (beats 0-7) driving the step-sequencer players.
// Latency: every output is a flop; beat/strobes/tempo change on the edge after their cause.
// Backpressure: none; pause freezes progress in place, sequencer_on=0 returns to idle.
//
// Ports:
//   clk            system clock (10 kHz)
//   rst            synchronous active-high reset
//   sequencer_on   1 = sequencer mode (beats advance), 0 = piano mode (held idle)
//   pause          level; 1 freezes tick and beat
//   tempo_up       synchronized button level; rising edge = tempo + 1
//   tempo_down     synchronized button level; rising edge = tempo - 1
//   beat           current beat 0-7 (bit 3 is always 0)
//   beat_strobe    one-cycle pulse when beat takes a new value
//   measure_start  one-cycle pulse together with beat_strobe when beat becomes 0
//   tempo          current tempo step, 0 (slowest) .. 7 (fastest)

module beat_clock #(
   parameter int BASE_TICKS  = 5000,
   parameter int STEP_TICKS  = 500,
   parameter int TEMPO_RESET = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sequencer_on,
   input  logic       pause,
   input  logic       tempo_up,
   input  logic       tempo_down,
   output logic [3:0] beat,
   output logic       beat_strobe,
   output logic       measure_start,
   output logic [2:0] tempo
);

   // Tick counter is at least 13 bits and always wide enough to hold BASE_TICKS.
   localparam int TW = ($clog2(BASE_TICKS + 1) > 13) ? $clog2(BASE_TICKS + 1) : 13;
   localparam logic [TW-1:0] PERIOD_RESET = TW'(BASE_TICKS - TEMPO_RESET * STEP_TICKS);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic [TW-1:0] tick;
   logic [TW-1:0] tick_nxt;
   logic [TW-1:0] period_latched;
   logic [TW-1:0] period_latched_nxt;
   logic [TW-1:0] period_now;
   logic          wrap;

   logic [2:0]    beat_cnt;
   logic [2:0]    beat_cnt_nxt;
   logic          strobe_nxt;
   logic          measure_nxt;

   logic          up_prev;
   logic          down_prev;
   logic          up_edge;
   logic          down_edge;
   logic [2:0]    tempo_nxt;

   // ------------------------------------------------------------------
   // Tempo buttons: one previous-value flop each, so a held button only
   // produces a single step. Both edges together cancel out.
   // ------------------------------------------------------------------
   assign up_edge   = tempo_up   & ~up_prev;
   assign down_edge = tempo_down & ~down_prev;

   always_comb begin
      tempo_nxt = tempo;
      if (up_edge && !down_edge && (tempo != 3'd7)) begin
         tempo_nxt = tempo + 3'd1;
      end else if (down_edge && !up_edge && (tempo != 3'd0)) begin
         tempo_nxt = tempo - 3'd1;
      end
   end

   // Beat period for the current tempo. Arithmetic is modulo 2^TW, which is
   // exact because the true result never exceeds BASE_TICKS and TW holds it.
   assign period_now = TW'(BASE_TICKS) - (TW'(tempo) * TW'(STEP_TICKS));

   // Last tick of the beat, judged against the period latched at beat start
   // so that a tempo change never stretches or shortens the beat in flight.
   assign wrap = (tick == (period_latched - TW'(1)));

   // ------------------------------------------------------------------
   // State register (plus the registered datapath it steers)
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         tick           <= '0;
         beat_cnt       <= '0;
         beat_strobe    <= 1'b0;
         measure_start  <= 1'b0;
         period_latched <= PERIOD_RESET;
         tempo          <= 3'(TEMPO_RESET);
         up_prev        <= 1'b0;
         down_prev      <= 1'b0;
      end else begin
         state          <= state_nxt;
         tick           <= tick_nxt;
         beat_cnt       <= beat_cnt_nxt;
         beat_strobe    <= strobe_nxt;
         measure_start  <= measure_nxt;
         period_latched <= period_latched_nxt;
         tempo          <= tempo_nxt;
         up_prev        <= tempo_up;
         down_prev      <= tempo_down;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic. Leaving sequencer mode beats pause, and pause beats
   // the end-of-beat wrap.
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (sequencer_on) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (!sequencer_on) begin
               state_nxt = IDLE;
            end else if (pause) begin
               state_nxt = PAUSED;
            end
         end
         PAUSED: begin
            if (!sequencer_on) begin
               state_nxt = IDLE;
            end else if (!pause) begin
               state_nxt = RUN;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output / datapath logic: next values of tick, beat, strobes and the
   // latched period. Strobes default low so they can only last one cycle.
   // ------------------------------------------------------------------
   always_comb begin
      tick_nxt           = tick;
      beat_cnt_nxt       = beat_cnt;
      strobe_nxt         = 1'b0;
      measure_nxt        = 1'b0;
      period_latched_nxt = period_latched;

      if (!sequencer_on) begin
         tick_nxt     = '0;
         beat_cnt_nxt = '0;
      end else begin
         case (state)
            IDLE: begin
               // Entering RUN announces beat 0 as the start of a measure.
               tick_nxt           = '0;
               beat_cnt_nxt       = '0;
               strobe_nxt         = 1'b1;
               measure_nxt        = 1'b1;
               period_latched_nxt = period_now;
            end
            RUN: begin
               if (!pause) begin
                  if (wrap) begin
                     tick_nxt           = '0;
                     beat_cnt_nxt       = beat_cnt + 3'd1;
                     strobe_nxt         = 1'b1;
                     measure_nxt        = (beat_cnt == 3'd7);
                     period_latched_nxt = period_now;
                  end else begin
                     tick_nxt = tick + TW'(1);
                  end
               end
            end
            PAUSED: begin
               // Tick and beat hold; resuming picks up from the frozen tick
               // without a strobe.
            end
            default: begin
               tick_nxt     = '0;
               beat_cnt_nxt = '0;
            end
         endcase
      end
   end

   assign beat = {1'b0, beat_cnt};

endmodule

// File: tb/tb_beat_clock.sv
// tb_beat_clock: self-checking bench for beat_clock (BASE_TICKS=20, STEP_TICKS=2, TEMPO_RESET=3).
// Beat periods used below: tempo 0 -> 20, 3 -> 14, 4 -> 12, 5 -> 10, 7 -> 6 cycles.
// Table vectors cover tempo/reset/state entry; a strobe scoreboard covers beat timing.

module tb_beat_clock;

   logic       clk = 1'b0;
   logic       rst;
   logic       sequencer_on;
   logic       pause;
   logic       tempo_up;
   logic       tempo_down;
   logic [3:0] beat;
   logic       beat_strobe;
   logic       measure_start;
   logic [2:0] tempo;

   int n_vec = 0;
   int n_bad = 0;
   int cyc_cnt = 0;
   logic sb_on = 1'b0;

   beat_clock #(
      .BASE_TICKS (20),
      .STEP_TICKS (2),
      .TEMPO_RESET(3)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .sequencer_on (sequencer_on),
      .pause        (pause),
      .tempo_up     (tempo_up),
      .tempo_down   (tempo_down),
      .beat         (beat),
      .beat_strobe  (beat_strobe),
      .measure_start(measure_start),
      .tempo        (tempo)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // ---------------- table vectors ----------------
   typedef struct packed {
      logic       rst;
      logic       seq;
      logic       pause;
      logic       up;
      logic       down;
      logic [3:0] beat;
      logic       strobe;
      logic       meas;
      logic [2:0] tempo;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs [NV];
   logic [8:0] exp_q [$];

   function automatic vec_t mk(input int r, input int s, input int p, input int u,
                               input int d, input int b, input int st, input int m,
                               input int t);
      vec_t v;
      v.rst    = r[0];
      v.seq    = s[0];
      v.pause  = p[0];
      v.up     = u[0];
      v.down   = d[0];
      v.beat   = 4'(b);
      v.strobe = st[0];
      v.meas   = m[0];
      v.tempo  = 3'(t);
      return v;
   endfunction

   // ---------------- strobe scoreboard ----------------
   typedef struct {
      int         cyc;
      logic [3:0] beat;
      logic       meas;
   } ev_t;

   ev_t ev_q [$];

   always @(posedge clk) begin
      #1;
      if (sb_on) begin
         if (beat_strobe) begin
            n_vec++;
            if (ev_q.size() == 0) begin
               n_bad++;
               $display("FAIL unexpected_strobe: cycle %0d beat %0d measure_start %0d, required no strobe",
                        cyc_cnt, beat, measure_start);
            end else begin
               ev_t e;
               e = ev_q.pop_front();
               if (cyc_cnt != e.cyc || beat != e.beat || measure_start != e.meas) begin
                  n_bad++;
                  $display("FAIL strobe_event: got cycle %0d beat %0d measure_start %0d, required cycle %0d beat %0d measure_start %0d",
                           cyc_cnt, beat, measure_start, e.cyc, e.beat, e.meas);
               end
            end
         end else if (measure_start) begin
            n_vec++;
            n_bad++;
            $display("FAIL lone_measure_start: cycle %0d measure_start without beat_strobe", cyc_cnt);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic chk(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc_cnt);
      end
   endtask

   task automatic push_ev(input int c, input int b, input int m);
      ev_t e;
      e.cyc  = c;
      e.beat = 4'(b);
      e.meas = m[0];
      ev_q.push_back(e);
   endtask

   task automatic drain(input string name);
      n_vec++;
      if (ev_q.size() != 0) begin
         n_bad++;
         $display("FAIL %s: %0d expected strobes never seen, first due cycle %0d beat %0d",
                  name, ev_q.size(), ev_q[0].cyc, ev_q[0].beat);
      end
      ev_q.delete();
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      sequencer_on = 1'b0;
      pause        = 1'b0;
      tempo_up     = 1'b0;
      tempo_down   = 1'b0;
      step(1);
      rst = 1'b0;
   endtask

   initial begin
      int k;
      logic [8:0] got;
      logic [8:0] want;

      //            rst seq pau up dn | beat stb meas tempo
      vecs[0]  = mk(1, 0, 0, 0, 0,   0, 0, 0, 3);  // reset state
      vecs[1]  = mk(0, 0, 0, 1, 0,   0, 0, 0, 4);  // up edge in IDLE
      vecs[2]  = mk(0, 0, 0, 1, 0,   0, 0, 0, 4);  // held: no second step
      vecs[3]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 4);
      vecs[4]  = mk(0, 0, 0, 1, 1,   0, 0, 0, 4);  // both edges cancel
      vecs[5]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 4);
      vecs[6]  = mk(0, 0, 0, 0, 1,   0, 0, 0, 3);  // down edge
      vecs[7]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 3);
      vecs[8]  = mk(0, 0, 0, 0, 1,   0, 0, 0, 2);
      vecs[9]  = mk(0, 0, 0, 1, 1,   0, 0, 0, 3);  // up edge while down is held
      vecs[10] = mk(0, 0, 0, 0, 0,   0, 0, 0, 3);
      vecs[11] = mk(1, 0, 0, 1, 0,   0, 0, 0, 3);  // reset wins, clears up_prev
      vecs[12] = mk(0, 0, 0, 1, 0,   0, 0, 0, 4);  // still-high button is a new edge
      vecs[13] = mk(0, 1, 0, 0, 0,   0, 1, 1, 4);  // IDLE -> RUN
      vecs[14] = mk(0, 1, 0, 0, 0,   0, 0, 0, 4);  // strobe is a single cycle
      vecs[15] = mk(0, 1, 1, 0, 0,   0, 0, 0, 4);  // RUN -> PAUSED
      vecs[16] = mk(0, 1, 1, 0, 1,   0, 0, 0, 3);  // tempo moves while paused
      vecs[17] = mk(0, 0, 1, 0, 0,   0, 0, 0, 3);  // off beats pause
      vecs[18] = mk(0, 1, 0, 0, 0,   0, 1, 1, 3);  // re-entry
      vecs[19] = mk(1, 1, 0, 0, 0,   0, 0, 0, 3);  // reset while running

      rst          = 1'b1;
      sequencer_on = 1'b0;
      pause        = 1'b0;
      tempo_up     = 1'b0;
      tempo_down   = 1'b0;
      step(1);

      for (int i = 0; i < NV; i++) begin
         rst          = vecs[i].rst;
         sequencer_on = vecs[i].seq;
         pause        = vecs[i].pause;
         tempo_up     = vecs[i].up;
         tempo_down   = vecs[i].down;
         exp_q.push_back({vecs[i].beat, vecs[i].strobe, vecs[i].meas, vecs[i].tempo});
         step(1);
         got  = {beat, beat_strobe, measure_start, tempo};
         want = exp_q.pop_front();
         n_vec++;
         if (got !== want) begin
            n_bad++;
            $display("FAIL vector_%0d: got beat %0d strobe %0d meas %0d tempo %0d, required beat %0d strobe %0d meas %0d tempo %0d",
                     i, got[8:5], got[4], got[3], got[2:0], want[8:5], want[4], want[3], want[2:0]);
         end
      end

      // ---- full measure at tempo 3 (period 14) ----
      do_reset();
      sb_on = 1'b1;
      k = cyc_cnt;
      sequencer_on = 1'b1;
      for (int b = 0; b < 8; b++) push_ev(k + 1 + 14 * b, b, (b == 0) ? 1 : 0);
      push_ev(k + 113, 0, 1);
      step(7);
      chk("beat0_mid", int'(beat), 0);
      step(106);
      drain("full_measure");
      chk("beat_after_measure", int'(beat), 0);

      // ---- tempo change mid-beat: current beat unchanged, next one shorter ----
      k = cyc_cnt;
      push_ev(k + 14, 1, 0);
      push_ev(k + 24, 2, 0);
      step(3);
      tempo_up = 1'b1;
      step(1);
      chk("tempo_first_up", int'(tempo), 4);
      tempo_up = 1'b0;
      step(1);
      tempo_up = 1'b1;
      step(1);
      chk("tempo_second_up", int'(tempo), 5);
      tempo_up = 1'b0;
      step(18);
      drain("tempo_change_spacing");
      chk("beat_after_tempo", int'(beat), 2);

      // ---- pause at tick 5 of beat 2 for 30 cycles ----
      do_reset();
      k = cyc_cnt;
      sequencer_on = 1'b1;
      push_ev(k + 1, 0, 1);
      push_ev(k + 15, 1, 0);
      push_ev(k + 29, 2, 0);
      step(34);
      chk("beat_before_pause", int'(beat), 2);
      pause = 1'b1;
      step(16);
      chk("beat_during_pause", int'(beat), 2);
      step(14);
      pause = 1'b0;
      push_ev(k + 74, 3, 0);
      step(9);
      chk("beat_just_before_resume_wrap", int'(beat), 2);
      step(1);
      drain("pause_resume");
      chk("beat_after_resume", int'(beat), 3);

      // ---- sequencer off at beat 6, then re-enable ----
      push_ev(k + 88, 4, 0);
      push_ev(k + 102, 5, 0);
      push_ev(k + 116, 6, 0);
      step(45);
      chk("beat_at_six", int'(beat), 6);
      sequencer_on = 1'b0;
      step(1);
      chk("seq_off_beat", int'(beat), 0);
      step(5);
      chk("seq_off_hold", int'(beat), 0);
      drain("seq_off");
      k = cyc_cnt;
      sequencer_on = 1'b1;
      push_ev(k + 1, 0, 1);
      push_ev(k + 15, 1, 0);
      step(15);
      drain("reenable");

      // ---- tempo saturation at both ends ----
      do_reset();
      for (int i = 0; i < 3; i++) begin
         tempo_down = 1'b1;
         step(1);
         tempo_down = 1'b0;
         step(1);
      end
      chk("tempo_down_to_0", int'(tempo), 0);
      tempo_down = 1'b1;
      step(50);
      chk("down_held_at_0", int'(tempo), 0);
      tempo_down = 1'b0;
      step(1);

      do_reset();
      for (int i = 0; i < 7; i++) begin
         tempo_up = 1'b1;
         step(1);
         chk("tempo_up_sat", int'(tempo), (4 + i > 7) ? 7 : 4 + i);
         tempo_up = 1'b0;
         step(1);
      end
      k = cyc_cnt;
      sequencer_on = 1'b1;
      push_ev(k + 1, 0, 1);
      push_ev(k + 7, 1, 0);
      push_ev(k + 13, 2, 0);
      step(13);
      drain("tempo7_period");

      // ---- reset mid-beat while paused at tempo 7 ----
      step(2);
      pause = 1'b1;
      step(3);
      rst = 1'b1;
      step(1);
      chk("rst_beat", int'(beat), 0);
      chk("rst_strobe", int'(beat_strobe), 0);
      chk("rst_measure", int'(measure_start), 0);
      chk("rst_tempo", int'(tempo), 3);
      rst   = 1'b0;
      pause = 1'b0;
      k = cyc_cnt;
      push_ev(k + 1, 0, 1);
      push_ev(k + 15, 1, 0);
      step(15);
      drain("post_reset_run");

      sb_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
